fifo_stream_reader: RTL and testbench

//  Read-side companion of the 8-bit FIFO: drains bytes via FIFO_RD_EN/FIFO_Empty/FIFO_Dout
//  and presents them as a valid/ready byte stream grouped into fixed-length bursts.

---
 rtl/fifo_stream_pkg.sv | 7 +
 rtl/fifo_stream_reader_if.sv | 13 +
 rtl/skid_buf2.sv | 22 ++
 rtl/fifo_stream_reader.sv | 69 ++++++
 tb/tb_fifo_stream_reader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared defaults and FSM state type for the FIFO stream reader
package fifo_stream_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_BURST_LEN = 4;
  localparam logic [DEF_DATA_W-1:0] DEF_PAD_BYTE = 8'h00;
  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus valid/ready burst stream of the reader
interface fifo_stream_reader_if import fifo_stream_pkg::*; #(parameter int DW = DEF_DATA_W);
  logic fifo_empty, fifo_rd_en, flush, m_valid, m_ready, m_last, m_pad, busy;
  logic [DW-1:0] fifo_dout, m_data;
  modport master(
    input fifo_empty, fifo_dout, flush, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last, m_pad, busy
  );
  modport slave(
    output fifo_empty, fifo_dout, flush, m_ready,
    input fifo_rd_en, m_data, m_valid, m_last, m_pad, busy
  );
endinterface

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry register FIFO; head is the oldest entry
module skid_buf2 #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);
  logic [W-1:0] tail;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= (push && (occ == 2'd0 || (pop && occ == 2'd1))) ? din : pop ? tail : head;
      tail <= (push && (pop ? occ == 2'd2 : occ == 2'd1)) ? din : tail;
      occ  <= occ + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a byte FIFO into a fixed-length burst stream, padding on flush
module fifo_stream_reader import fifo_stream_pkg::*; #(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                BURST_LEN = DEF_BURST_LEN,
  parameter logic [DATA_W-1:0] PAD_BYTE  = DEF_PAD_BYTE
) (
  input logic clk,
  input logic rst_n,
  fifo_stream_reader_if.master bus
);
  localparam int IW = $clog2(BURST_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(BURST_LEN - 1);
  state_t state, state_nxt;
  logic inflight, flush_pend, flush_pend_nxt, pop, xfer, drained;
  logic [1:0] occ;
  logic [DATA_W-1:0] head;
  logic [IW-1:0] idx;
  skid_buf2 #(.W(DATA_W)) u_buf (
    .clk(clk), .rst_n(rst_n), .push(inflight), .pop(pop),
    .din(bus.fifo_dout), .head(head), .occ(occ)
  );
  assign pop = bus.m_ready && occ != 2'd0;
  // a same-cycle pop frees a slot, so reads keep streaming at one byte per cycle
  assign bus.fifo_rd_en = rst_n && !bus.fifo_empty && state != PAD &&
                          ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
  assign bus.m_pad = state == PAD;
  assign bus.m_valid = occ != 2'd0 || bus.m_pad;
  assign bus.m_data = bus.m_pad ? PAD_BYTE : head;
  assign bus.m_last = bus.m_valid && idx == LAST_IDX;
  assign bus.busy = state != IDLE || occ != 2'd0 || inflight;
  assign xfer = bus.m_valid && bus.m_ready;
  assign drained = occ == 2'd0 && !inflight;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
      idx        <= '0;
    end else begin
      state      <= state_nxt;
      inflight   <= bus.fifo_rd_en;
      flush_pend <= flush_pend_nxt;
      idx        <= xfer ? (idx == LAST_IDX ? '0 : idx + 1'b1) : idx;
    end
  always_comb begin
    state_nxt = state;
    flush_pend_nxt = flush_pend;
    case (state)
      IDLE: state_nxt = bus.fifo_rd_en ? RUN : IDLE;
      RUN: begin
        if (bus.flush && (idx != '0 || !drained)) flush_pend_nxt = 1'b1;
        // refilled data takes priority; only an empty pipeline may close the burst
        if (drained && !bus.fifo_rd_en) begin
          if (idx == '0) begin
            state_nxt = IDLE;
            flush_pend_nxt = 1'b0;
          end else if (flush_pend) begin
            state_nxt = PAD;
          end
        end
      end
      PAD: if (xfer && bus.m_last) begin
        state_nxt = IDLE;
        flush_pend_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and random checks of the FIFO stream reader
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fifo_stream_reader_if #(.DW(8)) ifc();
  fifo_stream_reader #(.DATA_W(8), .BURST_LEN(4), .PAD_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.master)
  );
  int n_cmp = 0, n_bad = 0, rd_cnt = 0, underflow = 0;
  logic [7:0] fq[$];
  logic [7:0] bq_data[$];
  logic bq_last[$], bq_pad[$];
  logic hold_empty = 1'b0, rd_go = 1'b0, prev_hold = 1'b0;
  logic [7:0] pend = 8'h00;
  logic [9:0] prev_beat = '0;
  always @(posedge clk) begin
    if (rd_go) ifc.fifo_dout <= pend;
    ifc.fifo_empty <= hold_empty || fq.size() == 0;
  end
  always @(negedge clk) begin
    rd_go = ifc.fifo_rd_en;
    if (ifc.fifo_rd_en) begin
      rd_cnt++;
      if (ifc.fifo_empty || fq.size() == 0) begin
        underflow++;
        $display("FAIL underflow: fifo_rd_en=1 with fifo_empty=%b at %0t", ifc.fifo_empty, $time);
      end else pend = fq.pop_front();
    end
    if (prev_hold && ifc.m_valid) begin
      n_cmp++;
      if ({ifc.m_data, ifc.m_last, ifc.m_pad} !== prev_beat) begin
        n_bad++;
        $display("FAIL hold_stable: got %h want %h at %0t", {ifc.m_data, ifc.m_last, ifc.m_pad}, prev_beat, $time);
      end
    end
    prev_hold = ifc.m_valid && !ifc.m_ready;
    prev_beat = {ifc.m_data, ifc.m_last, ifc.m_pad};
    if (ifc.m_valid && ifc.m_ready) begin
      bq_data.push_back(ifc.m_data);
      bq_last.push_back(ifc.m_last);
      bq_pad.push_back(ifc.m_pad);
    end
  end
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); #1; endtask
  task automatic clear_mon(); bq_data.delete(); bq_last.delete(); bq_pad.delete(); endtask
  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (bq_data.size() < n && c < budget) begin sample(); c++; end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    sample();
    n_cmp++;
    if ({ifc.fifo_rd_en, ifc.m_valid, ifc.m_last, ifc.m_pad, ifc.busy, ifc.m_data} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_init: got %h want 0", {ifc.fifo_rd_en, ifc.m_valid, ifc.m_last, ifc.m_pad, ifc.busy, ifc.m_data});
    end
    tick(); rst_n = 1'b1;
    repeat (3) begin
      sample(); n_cmp++;
      if ({ifc.fifo_rd_en, ifc.busy} !== 2'b00) begin
        n_bad++; $display("FAIL idle_no_read: got rd_en,busy=%b want 00", {ifc.fifo_rd_en, ifc.busy});
      end
    end
    tick();
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h50 + i));
    repeat (6) sample();
    n_cmp++;
    if ({ifc.m_valid, ifc.busy, ifc.m_data} !== {2'b11, 8'h50}) begin
      n_bad++; $display("FAIL pre_reset_stall: got %h want %h", {ifc.m_valid, ifc.busy, ifc.m_data}, {2'b11, 8'h50});
    end
    tick(); rst_n = 1'b0; #1;
    n_cmp++;
    if ({ifc.fifo_rd_en, ifc.m_valid, ifc.m_last, ifc.m_pad, ifc.busy, ifc.m_data} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got %h want 0", {ifc.fifo_rd_en, ifc.m_valid, ifc.m_last, ifc.m_pad, ifc.busy, ifc.m_data});
    end
    fq.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) begin
      sample(); n_cmp++;
      if ({ifc.fifo_rd_en, ifc.busy, ifc.m_valid} !== 3'b000) begin
        n_bad++; $display("FAIL post_reset_idle: got %b want 000", {ifc.fifo_rd_en, ifc.busy, ifc.m_valid});
      end
    end
    clear_mon();
  endtask
  task automatic test_stream();
    tick(); ifc.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h11 + i));
    sample(); sample();
    n_cmp++;
    if ({ifc.fifo_rd_en, ifc.m_valid} !== 2'b10) begin
      n_bad++; $display("FAIL latency_read: got rd_en,valid=%b want 10", {ifc.fifo_rd_en, ifc.m_valid});
    end
    sample(); n_cmp++;
    if (ifc.m_valid !== 1'b0) begin n_bad++; $display("FAIL latency_capture: got valid=%b want 0", ifc.m_valid); end
    sample(); n_cmp++;
    if ({ifc.m_valid, ifc.m_data} !== {1'b1, 8'h11}) begin
      n_bad++; $display("FAIL first_beat: got %h want %h", {ifc.m_valid, ifc.m_data}, {1'b1, 8'h11});
    end
    repeat (7) sample();
    n_cmp++;
    if (bq_data.size() != 8) begin n_bad++; $display("FAIL throughput: got %0d beats want 8", bq_data.size()); end
    wait_beats(8, 10);
    for (int i = 0; i < 8 && i < bq_data.size(); i++) begin
      n_cmp++;
      if ({bq_data[i], bq_last[i], bq_pad[i]} !== {8'(8'h11 + i), i % 4 == 3, 1'b0}) begin
        n_bad++;
        $display("FAIL stream_beat%0d: got %h want %h", i, {bq_data[i], bq_last[i], bq_pad[i]}, {8'(8'h11 + i), i % 4 == 3, 1'b0});
      end
    end
    repeat (3) sample();
    n_cmp++;
    if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL stream_idle: got busy=%b want 0", ifc.busy); end
    clear_mon();
  endtask
  task automatic test_backpressure();
    int rc0;
    tick(); ifc.m_ready = 1'b0; rc0 = rd_cnt;
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h21 + i));
    repeat (10) begin
      sample();
      if (ifc.m_valid) begin
        n_cmp++;
        if (ifc.m_data !== 8'h21) begin n_bad++; $display("FAIL stall_data: got %h want 21", ifc.m_data); end
      end
    end
    n_cmp++;
    if (rd_cnt - rc0 != 2) begin n_bad++; $display("FAIL stall_reads: got %0d want 2", rd_cnt - rc0); end
    n_cmp++;
    if (bq_data.size() != 0) begin n_bad++; $display("FAIL stall_beats: got %0d want 0", bq_data.size()); end
    tick(); ifc.m_ready = 1'b1;
    wait_beats(8, 20);
    n_cmp++;
    if (bq_data.size() != 8) begin n_bad++; $display("FAIL release_count: got %0d want 8", bq_data.size()); end
    for (int i = 0; i < 8 && i < bq_data.size(); i++) begin
      n_cmp++;
      if ({bq_data[i], bq_last[i]} !== {8'(8'h21 + i), i % 4 == 3}) begin
        n_bad++; $display("FAIL release_beat%0d: got %h want %h", i, {bq_data[i], bq_last[i]}, {8'(8'h21 + i), i % 4 == 3});
      end
    end
    clear_mon();
  endtask
  task automatic test_flush();
    tick(); ifc.m_ready = 1'b1;
    fq.push_back(8'h31); fq.push_back(8'h32); fq.push_back(8'h33);
    wait_beats(3, 20);
    repeat (4) sample();
    n_cmp++;
    if ({bq_data.size() == 3, ifc.busy, ifc.m_valid} !== 3'b110) begin
      n_bad++; $display("FAIL partial_wait: got beats=%0d busy=%b valid=%b want 3/1/0", bq_data.size(), ifc.busy, ifc.m_valid);
    end
    tick(); ifc.flush = 1'b1;
    tick(); ifc.flush = 1'b0;
    wait_beats(4, 10);
    n_cmp++;
    if (bq_data.size() != 4) begin n_bad++; $display("FAIL flush_count: got %0d want 4", bq_data.size()); end
    for (int i = 0; i < 4 && i < bq_data.size(); i++) begin
      n_cmp++;
      if ({bq_data[i], bq_last[i], bq_pad[i]} !== (i == 3 ? {8'hA5, 2'b11} : {8'(8'h31 + i), 2'b00})) begin
        n_bad++; $display("FAIL flush_beat%0d: got %h", i, {bq_data[i], bq_last[i], bq_pad[i]});
      end
    end
    repeat (3) sample();
    n_cmp++;
    if ({ifc.busy, ifc.m_valid, bq_data.size() == 4} !== 3'b001) begin
      n_bad++; $display("FAIL flush_idle: got busy=%b valid=%b beats=%0d want 0/0/4", ifc.busy, ifc.m_valid, bq_data.size());
    end
    clear_mon();
  endtask
  task automatic test_flush_idle();
    tick(); ifc.flush = 1'b1;
    tick(); ifc.flush = 1'b0;
    repeat (6) sample();
    n_cmp++;
    if ({bq_data.size() == 0, ifc.busy, ifc.m_valid} !== 3'b100) begin
      n_bad++; $display("FAIL idle_flush: got beats=%0d busy=%b valid=%b want 0/0/0", bq_data.size(), ifc.busy, ifc.m_valid);
    end
    tick(); fq.push_back(8'h41); fq.push_back(8'h42);
    repeat (10) sample();
    n_cmp++;
    if ({bq_data.size() == 2, ifc.busy, ifc.m_valid} !== 3'b110) begin
      n_bad++; $display("FAIL no_stale_flush: got beats=%0d busy=%b valid=%b want 2/1/0", bq_data.size(), ifc.busy, ifc.m_valid);
    end
    tick(); fq.push_back(8'h43); fq.push_back(8'h44);
    wait_beats(4, 20);
    n_cmp++;
    if (bq_data.size() != 4 || {bq_data[3], bq_last[3], bq_pad[3]} !== {8'h44, 2'b10}) begin
      n_bad++; $display("FAIL burst_complete: got %0d beats, last beat %h want 4 beats, %h",
                        bq_data.size(), bq_data.size() == 4 ? {bq_data[3], bq_last[3], bq_pad[3]} : 10'h0, {8'h44, 2'b10});
    end
    clear_mon();
  endtask
  task automatic test_random();
    logic [7:0] exp[$];
    int c = 0;
    tick();
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] b = 8'($urandom);
      fq.push_back(b); exp.push_back(b);
    end
    while (bq_data.size() < 1000 && c < 8000) begin
      tick();
      hold_empty = $urandom_range(0, 3) == 0;
      ifc.m_ready = $urandom_range(0, 2) != 0;
      c++;
    end
    hold_empty = 1'b0; ifc.m_ready = 1'b1;
    n_cmp++;
    if (bq_data.size() != 1000) begin n_bad++; $display("FAIL random_count: got %0d want 1000", bq_data.size()); end
    for (int i = 0; i < 1000 && i < bq_data.size(); i++) begin
      n_cmp++;
      if ({bq_data[i], bq_last[i], bq_pad[i]} !== {exp[i], i % 4 == 3, 1'b0}) begin
        n_bad++; $display("FAIL random_beat%0d: got %h want %h", i, {bq_data[i], bq_last[i], bq_pad[i]}, {exp[i], i % 4 == 3, 1'b0});
      end
    end
    repeat (4) sample();
    n_cmp++;
    if (underflow != 0) begin n_bad++; $display("FAIL no_underflow: got %0d underflows want 0", underflow); end
    n_cmp++;
    if ({ifc.busy, ifc.m_valid} !== 2'b00) begin
      n_bad++; $display("FAIL random_idle: got busy=%b valid=%b want 0/0", ifc.busy, ifc.m_valid);
    end
  endtask
  initial begin
    ifc.flush = 1'b0;
    ifc.m_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
